// File: rtl/rgb2hsv_param_if.sv
// rtl/rgb2hsv_param_if.sv - pixel in/out bundle for the RGB to HSV converter
interface rgb2hsv_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] R, G, B;
    logic              in_hsync, in_vsync, in_de;
    logic [DATA_W-1:0] H, S, V;
    logic              out_hsync, out_vsync, out_de;

    modport master (
        output R, G, B, in_hsync, in_vsync, in_de,
        input  H, S, V, out_hsync, out_vsync, out_de
    );

    modport slave (
        input  R, G, B, in_hsync, in_vsync, in_de,
        output H, S, V, out_hsync, out_vsync, out_de
    );
endinterface

// File: rtl/rgb2hsv_param.sv
// rtl/rgb2hsv_param.sv - pipelined RGB to HSV converter, latency DATA_W+4 ce edges
// Optional per-pixel pass-through enabled by macro RGB2HSV_BYPASS_EN.
module rgb2hsv_param #(
    parameter int DATA_W = 8,
    parameter int SECT   = 43
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
`ifdef RGB2HSV_BYPASS_EN
    input  logic bypass,
`endif
    rgb2hsv_param_if.slave px
);
    localparam int W  = DATA_W;
    localparam int L  = W + 4;
    localparam int SW = W + 2;
    localparam int DW = 2 * W;
    localparam int NS = W + 2;

    logic [W-1:0]  r1_d, g1_d, b1_d, r1_q, g1_q, b1_q;
    logic [W-1:0]  max2_d, delta2_d, base2_d, max2_q, delta2_q, base2_q;
    logic [SW-1:0] num2_d, num2_q;
    logic [W-1:0]  min2;

    logic [DW-1:0] rs_d [1:W], rs_q [1:W], rh_d [1:W], rh_q [1:W];
    logic [W-1:0]  qs_d [1:W], qs_q [1:W], qh_d [1:W], qh_q [1:W];
    logic [W-1:0]  dvs_d [1:W], dvs_q [1:W], dvh_d [1:W], dvh_q [1:W];
    logic [W-1:0]  base_d [1:W], base_q [1:W];
    logic          neg_d [1:W], neg_q [1:W];

    logic [DW-1:0] ps [0:W-1], ph [0:W-1];
    logic [W-1:0]  pqs [0:W-1], pqh [0:W-1], pds [0:W-1], pdh [0:W-1], pbase [0:W-1];
    logic          pneg [0:W-1];
    logic [DW-1:0] shs, shh;
    logic [W-1:0]  mag;
    logic signed [SW-1:0] offs, hue;

    logic [W-1:0]  hf_d, sf_d, vf_d, hf_q, sf_q, vf_q;
    logic [W-1:0]  h_d, s_d, v_d, h_q, s_q, v_q;
    logic [2:0]    tim_d [0:L-1], tim_q [0:L-1];

`ifdef RGB2HSV_BYPASS_EN
    logic          byp_d [1:NS], byp_q [1:NS];
    logic [3*W-1:0] raw_d [1:NS], raw_q [1:NS];
`endif

    always_comb begin
        r1_d = px.R;
        g1_d = px.G;
        b1_d = px.B;

        // Ties resolve R over G over B, so >= on the earlier channel.
        if (r1_q >= g1_q && r1_q >= b1_q) begin
            max2_d  = r1_q;
            num2_d  = $signed({2'b00, g1_q}) - $signed({2'b00, b1_q});
            base2_d = '0;
        end else if (g1_q >= b1_q) begin
            max2_d  = g1_q;
            num2_d  = $signed({2'b00, b1_q}) - $signed({2'b00, r1_q});
            base2_d = W'(2 * SECT);
        end else begin
            max2_d  = b1_q;
            num2_d  = $signed({2'b00, r1_q}) - $signed({2'b00, g1_q});
            base2_d = W'(4 * SECT);
        end
        min2 = r1_q;
        if (g1_q < min2) min2 = g1_q;
        if (b1_q < min2) min2 = b1_q;
        delta2_d = max2_d - min2;

        mag      = num2_q[SW-1] ? W'(-num2_q) : W'(num2_q);
        ps[0]    = {delta2_q, {W{1'b0}}} - {{W{1'b0}}, delta2_q};
        ph[0]    = DW'(SECT) * {{W{1'b0}}, mag};
        pqs[0]   = '0;
        pqh[0]   = '0;
        pds[0]   = max2_q;
        pdh[0]   = delta2_q;
        pneg[0]  = num2_q[SW-1];
        pbase[0] = base2_q;
        for (int k = 1; k < W; k++) begin
            ps[k]    = rs_q[k];
            ph[k]    = rh_q[k];
            pqs[k]   = qs_q[k];
            pqh[k]   = qh_q[k];
            pds[k]   = dvs_q[k];
            pdh[k]   = dvh_q[k];
            pneg[k]  = neg_q[k];
            pbase[k] = base_q[k];
        end

        // Both quotients are below 2^W, so the divisor starts shifted by W-1.
        shs = '0;
        shh = '0;
        for (int k = 0; k < W; k++) begin
            shs = {{W{1'b0}}, pds[k]} << (W - 1 - k);
            shh = {{W{1'b0}}, pdh[k]} << (W - 1 - k);
            if (ps[k] >= shs) begin
                rs_d[k+1] = ps[k] - shs;
                qs_d[k+1] = pqs[k] | (W'(1) << (W - 1 - k));
            end else begin
                rs_d[k+1] = ps[k];
                qs_d[k+1] = pqs[k];
            end
            if (ph[k] >= shh) begin
                rh_d[k+1] = ph[k] - shh;
                qh_d[k+1] = pqh[k] | (W'(1) << (W - 1 - k));
            end else begin
                rh_d[k+1] = ph[k];
                qh_d[k+1] = pqh[k];
            end
            dvs_d[k+1]  = pds[k];
            dvh_d[k+1]  = pdh[k];
            neg_d[k+1]  = pneg[k];
            base_d[k+1] = pbase[k];
        end

        offs = $signed({2'b00, qh_q[W]});
        hue  = $signed({2'b00, base_q[W]}) + (neg_q[W] ? -offs : offs);
        hf_d = (dvh_q[W] == '0) ? '0 : hue[W-1:0];
        sf_d = (dvh_q[W] == '0) ? '0 : qs_q[W];
        vf_d = dvs_q[W];

`ifdef RGB2HSV_BYPASS_EN
        byp_d[1] = bypass;
        raw_d[1] = {px.R, px.G, px.B};
        for (int k = 2; k <= NS; k++) begin
            byp_d[k] = byp_q[k-1];
            raw_d[k] = raw_q[k-1];
        end
        if (byp_q[NS]) {hf_d, sf_d, vf_d} = raw_q[NS];
`endif

        h_d = hf_q;
        s_d = sf_q;
        v_d = vf_q;

        tim_d[0] = {px.in_hsync, px.in_vsync, px.in_de};
        for (int k = 1; k < L; k++) tim_d[k] = tim_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r1_q, g1_q, b1_q} <= '0;
            {max2_q, delta2_q, base2_q, num2_q} <= '0;
            for (int k = 1; k <= W; k++) begin
                rs_q[k] <= '0; rh_q[k] <= '0; qs_q[k] <= '0; qh_q[k] <= '0;
                dvs_q[k] <= '0; dvh_q[k] <= '0; neg_q[k] <= 1'b0; base_q[k] <= '0;
            end
            {hf_q, sf_q, vf_q, h_q, s_q, v_q} <= '0;
            for (int k = 0; k < L; k++) tim_q[k] <= '0;
`ifdef RGB2HSV_BYPASS_EN
            for (int k = 1; k <= NS; k++) begin
                byp_q[k] <= 1'b0;
                raw_q[k] <= '0;
            end
`endif
        end else if (ce) begin
            {r1_q, g1_q, b1_q} <= {r1_d, g1_d, b1_d};
            {max2_q, delta2_q, base2_q, num2_q} <= {max2_d, delta2_d, base2_d, num2_d};
            for (int k = 1; k <= W; k++) begin
                rs_q[k] <= rs_d[k]; rh_q[k] <= rh_d[k]; qs_q[k] <= qs_d[k]; qh_q[k] <= qh_d[k];
                dvs_q[k] <= dvs_d[k]; dvh_q[k] <= dvh_d[k]; neg_q[k] <= neg_d[k]; base_q[k] <= base_d[k];
            end
            {hf_q, sf_q, vf_q, h_q, s_q, v_q} <= {hf_d, sf_d, vf_d, h_d, s_d, v_d};
            for (int k = 0; k < L; k++) tim_q[k] <= tim_d[k];
`ifdef RGB2HSV_BYPASS_EN
            for (int k = 1; k <= NS; k++) begin
                byp_q[k] <= byp_d[k];
                raw_q[k] <= raw_d[k];
            end
`endif
        end
    end

    assign px.H = h_q;
    assign px.S = s_q;
    assign px.V = v_q;
    assign {px.out_hsync, px.out_vsync, px.out_de} = tim_q[L-1];
endmodule
